bmp_header_gen: RTL

BMP_HEADER_GEN -- requirements
Module: bmp_header_gen

---
 rtl/bmp_header_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bmp_header_gen.sv
// Purpose: writes a 54-byte BMP header (BITMAPFILEHEADER + BITMAPINFOHEADER) for a bounding box; BMP_HDR_BPP32_EN adds a bpp32 input.
// Latency: start -> CALC0 -> CALC1 -> first write in the third cycle, then one write per cycle while mem_ready=1.
// Backpressure: mem_ready=0 stalls indefinitely with addr/wrdata/wren held unchanged.
module bmp_header_gen #(
   parameter int                ADDR_W    = 24,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [10:0]       xMin,
   input  logic [10:0]       xMax,
   input  logic [10:0]       yMin,
   input  logic [10:0]       yMax,
   input  logic              mem_ready,
`ifdef BMP_HDR_BPP32_EN
   input  logic              bpp32,
`endif
   output logic [ADDR_W-1:0] addr,
   output logic              wren,
   output logic [DATA_W-1:0] wrdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // 16-bit port packs two header bytes per write, so it needs half as many writes
   localparam int         NUM_WR   = (DATA_W == 16) ? 27 : 54;
   localparam logic [5:0] LAST_IDX = 6'(NUM_WR - 1);
   localparam int         HDR_BITS = 54 * 8;
   localparam logic [8:0] DW9      = 9'(DATA_W);

   typedef enum logic [2:0] {
      IDLE,
      CALC0,
      CALC1,
      WRITE,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [10:0]         x_min_q, x_min_d;
   logic [10:0]         x_max_q, x_max_d;
   logic [10:0]         y_min_q, y_min_d;
   logic [10:0]         y_max_q, y_max_d;
   logic [11:0]         w_q, w_d;
   logic [11:0]         h_q, h_d;
   logic [31:0]         img_size_q, img_size_d;
   logic [31:0]         file_size_q, file_size_d;
   logic [5:0]          idx_q, idx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wren_q, wren_d;
   logic [DATA_W-1:0]   wrdata_q, wrdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                wide_px;
   logic [31:0]         bytes_per_px;
   logic [31:0]         row_bytes;
   logic [HDR_BITS-1:0] hdr_vec;
   logic [8:0]          bit_off;

`ifdef BMP_HDR_BPP32_EN
   logic                bpp32_q, bpp32_d;
   assign wide_px = bpp32_q;
`else
   assign wide_px = 1'b0;
`endif

   // Next-state, datapath and registered-output values for the header sequencer
   always_comb begin
      state_d     = state_q;
      x_min_d     = x_min_q;
      x_max_d     = x_max_q;
      y_min_d     = y_min_q;
      y_max_d     = y_max_q;
      w_d         = w_q;
      h_d         = h_q;
      img_size_d  = img_size_q;
      file_size_d = file_size_q;
      idx_d       = idx_q;
      done_d      = done_q;
      err_d       = err_q;
`ifdef BMP_HDR_BPP32_EN
      bpp32_d     = bpp32_q;
`endif

      // Rows are padded to 4 bytes; 32-bit math keeps W=2048 at 4 bytes/pixel exact
      bytes_per_px = wide_px ? 32'd4 : 32'd3;
      row_bytes    = ((32'(w_q) * bytes_per_px) + 32'd3) & ~32'd3;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               x_min_d = xMin;
               x_max_d = xMax;
               y_min_d = yMin;
               y_max_d = yMax;
`ifdef BMP_HDR_BPP32_EN
               bpp32_d = bpp32;
`endif
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = CALC0;
            end
         end
         CALC0: begin
            w_d = {1'b0, x_max_q} - {1'b0, x_min_q} + 12'd1;
            h_d = {1'b0, y_max_q} - {1'b0, y_min_q} + 12'd1;
            // An inverted box produces no header at all, only the error flag
            if ((x_max_q < x_min_q) || (y_max_q < y_min_q)) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               state_d = CALC1;
            end
         end
         CALC1: begin
            img_size_d  = row_bytes * 32'(h_q);
            file_size_d = img_size_d + 32'd54;
            idx_d       = 6'd0;
            state_d     = WRITE;
         end
         WRITE: begin
            if (mem_ready) begin
               if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Whole header laid out little-endian, byte 0 in the least significant bits.
      // Size fields come from the _d values so the first write after CALC1 already sees them.
      hdr_vec = {32'd0,                      // bytes 50..53 important colours
                 32'd0,                      // bytes 46..49 palette colours
                 32'd2835,                   // bytes 42..45 y pixels per metre
                 32'd2835,                   // bytes 38..41 x pixels per metre
                 img_size_d,                 // bytes 34..37 image size
                 32'd0,                      // bytes 30..33 compression (BI_RGB)
                 (wide_px ? 16'd32 : 16'd24),// bytes 28..29 bits per pixel
                 16'd1,                      // bytes 26..27 colour planes
                 {20'd0, h_q},               // bytes 22..25 height
                 {20'd0, w_q},               // bytes 18..21 width
                 32'd40,                     // bytes 14..17 info header size
                 32'd54,                     // bytes 10..13 pixel data offset
                 32'd0,                      // bytes  6..9  reserved
                 file_size_d,                // bytes  2..5  file size
                 8'h4D, 8'h42};              // bytes  0..1  "BM"

      bit_off = {3'b000, idx_d} * DW9;

      wren_d   = (state_d == WRITE);
      busy_d   = (state_d == CALC0) || (state_d == CALC1) || (state_d == WRITE);
      addr_d   = '0;
      wrdata_d = '0;
      // During a stall idx is unchanged, so addr/wrdata recompute to the same values
      if (wren_d) begin
         addr_d   = BASE_ADDR + ADDR_W'(idx_d);
         wrdata_d = hdr_vec[bit_off +: DATA_W];
      end
   end

   // State and output registers; reset aborts any header in flight and wins over start
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_min_q     <= '0;
         x_max_q     <= '0;
         y_min_q     <= '0;
         y_max_q     <= '0;
         w_q         <= '0;
         h_q         <= '0;
         img_size_q  <= '0;
         file_size_q <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         wren_q      <= 1'b0;
         wrdata_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef BMP_HDR_BPP32_EN
         bpp32_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         x_min_q     <= x_min_d;
         x_max_q     <= x_max_d;
         y_min_q     <= y_min_d;
         y_max_q     <= y_max_d;
         w_q         <= w_d;
         h_q         <= h_d;
         img_size_q  <= img_size_d;
         file_size_q <= file_size_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         wren_q      <= wren_d;
         wrdata_q    <= wrdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef BMP_HDR_BPP32_EN
         bpp32_q     <= bpp32_d;
`endif
      end
   end

   assign addr   = addr_q;
   assign wren   = wren_q;
   assign wrdata = wrdata_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule
